// File: rtl/sync_fifo_tx_pkg.sv
// Shared defaults and the threshold helper for the single-clock TX FIFO.
package sync_fifo_tx_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic {
    THR_AT_LEAST,
    THR_AT_MOST
  } thr_dir_e;

  // Almost-full is an "at least" test, almost-empty an "at most" test.
  function automatic logic thr_hit(input int value, input int limit, input thr_dir_e dir);
    return (dir == THR_AT_LEAST) ? (value >= limit) : (value <= limit);
  endfunction

endpackage

// File: rtl/sync_fifo_tx_ram.sv
// Simple dual-port RAM for the TX FIFO: one write port, one registered read port.
module sync_fifo_tx_ram
  import sync_fifo_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  // NOTE: no reset on the array or its read register, so the tools can map it to block RAM;
  // the top level never presents read data that was not written since reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_tx_param.sv
// Single-clock parametrised TX FIFO with thresholds, occupancy count and sticky errors.
// Define SYNC_FIFO_TX_FWFT_EN for first-word-fall-through output mode.
module sync_fifo_tx_param
  import sync_fifo_tx_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_MARGIN = 4,
  parameter int AE_MARGIN = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_write_en,
  input  logic [DATA_W-1:0] i_WDATA,
  output logic              o_fifo_full,
  output logic              o_fifo_almst_full,
  input  logic              i_read_en,
  output logic [DATA_W-1:0] o_RDATA,
  output logic              o_rd_valid,
  output logic              o_fifo_empty,
  output logic              o_fifo_almst_empty,
  output logic [ADDR_W:0]   o_fifo_cnt,
  input  logic              i_err_clr,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]   r_wr_ptr, r_rd_ptr, r_cnt;
  logic              r_full, r_empty, r_almst_full, r_almst_empty;
  logic              r_ovf, r_udf, r_rd_valid, r_stage_vld;
  logic [DATA_W-1:0] r_rdata;

  logic              w_push, w_pop, w_ram_rd, w_rd_valid_nxt, w_empty_nxt;
  logic [ADDR_W:0]   w_wr_ptr_nxt, w_rd_ptr_nxt, w_ram_cnt_nxt, w_cnt_nxt;
  logic [DATA_W-1:0] w_ram_q;

  // Accept decisions use only registered flags, i.e. the state before the edge.
  assign w_push = i_write_en && !r_full;
  assign w_pop  = i_read_en && !r_empty;

`ifdef SYNC_FIFO_TX_FWFT_EN
  // At most one word lives outside the RAM (in flight or in the output register),
  // so the total occupancy tops out at DEPTH+1.
  assign w_ram_rd       = (r_wr_ptr != r_rd_ptr) && !r_stage_vld && (!r_rd_valid || w_pop);
  assign w_rd_valid_nxt = r_stage_vld || (r_rd_valid && !w_pop);
  assign w_empty_nxt    = !w_rd_valid_nxt;
`else
  assign w_ram_rd       = w_pop;
  assign w_rd_valid_nxt = r_stage_vld;
  assign w_empty_nxt    = (w_cnt_nxt == '0);
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_wr_ptr_nxt  = r_wr_ptr + (w_push ? ONE_C : '0);
    w_rd_ptr_nxt  = r_rd_ptr + (w_ram_rd ? ONE_C : '0);
    w_ram_cnt_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
    w_cnt_nxt     = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + ONE_C;
    else if (w_pop && !w_push) w_cnt_nxt = r_cnt - ONE_C;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_cnt         <= '0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_almst_full  <= 1'b0;
      r_almst_empty <= 1'b1;
      r_ovf         <= 1'b0;
      r_udf         <= 1'b0;
      r_stage_vld   <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_full        <= (w_ram_cnt_nxt == DEPTH_C);
      r_empty       <= w_empty_nxt;
      r_almst_full  <= thr_hit(int'(w_cnt_nxt), DEPTH - AF_MARGIN, THR_AT_LEAST);
      r_almst_empty <= thr_hit(int'(w_cnt_nxt), AE_MARGIN, THR_AT_MOST);
      // A fresh error wins over a same-cycle clear.
      r_ovf         <= (i_write_en && r_full) || (r_ovf && !i_err_clr);
      r_udf         <= (i_read_en && r_empty) || (r_udf && !i_err_clr);
      r_stage_vld   <= w_ram_rd;
      r_rd_valid    <= w_rd_valid_nxt;
      if (r_stage_vld) r_rdata <= w_ram_q;
    end
  end

  sync_fifo_tx_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data (i_WDATA),
    .i_rd_en   (w_ram_rd),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data (w_ram_q)
  );

  assign o_fifo_full        = r_full;
  assign o_fifo_almst_full  = r_almst_full;
  assign o_fifo_empty       = r_empty;
  assign o_fifo_almst_empty = r_almst_empty;
  assign o_fifo_cnt         = r_cnt;
  assign o_overflow         = r_ovf;
  assign o_underflow        = r_udf;
  assign o_rd_valid         = r_rd_valid;
  assign o_RDATA            = r_rdata;

endmodule

// File: tb/tb_sync_fifo_tx_param.sv
// Self-checking bench for sync_fifo_tx_param (DATA_W=8, ADDR_W=4); FWFT path when SYNC_FIFO_TX_FWFT_EN is defined.
module tb_sync_fifo_tx_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AF_LIM = 12;
  localparam int AE_LIM = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              we  = 1'b0;
  logic              re  = 1'b0;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] wd  = '0;

  logic              o_fifo_full, o_fifo_almst_full, o_rd_valid, o_fifo_empty;
  logic              o_fifo_almst_empty, o_overflow, o_underflow;
  logic [DATA_W-1:0] o_RDATA;
  logic [ADDR_W:0]   o_fifo_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo_tx_param #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .AF_MARGIN (4),
    .AE_MARGIN (4)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_write_en         (we),
    .i_WDATA            (wd),
    .o_fifo_full        (o_fifo_full),
    .o_fifo_almst_full  (o_fifo_almst_full),
    .i_read_en          (re),
    .o_RDATA            (o_RDATA),
    .o_rd_valid         (o_rd_valid),
    .o_fifo_empty       (o_fifo_empty),
    .o_fifo_almst_empty (o_fifo_almst_empty),
    .o_fifo_cnt         (o_fifo_cnt),
    .i_err_clr          (clr),
    .o_overflow         (o_overflow),
    .o_underflow        (o_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: queue of stored words, one pending read result, sticky errors.
  logic [DATA_W-1:0] m_q[$];
  bit                m_pend      = 1'b0;
  logic [DATA_W-1:0] m_pend_data = '0;
  bit                m_valid     = 1'b0;
  logic [DATA_W-1:0] m_rdata     = '0;
  bit                m_ovf       = 1'b0;
  bit                m_udf       = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_pend      = 1'b0;
      m_pend_data = '0;
      m_valid     = 1'b0;
      m_rdata     = '0;
      m_ovf       = 1'b0;
      m_udf       = 1'b0;
    end else begin
      bit full_b, empty_b, push, pop;
      full_b  = (m_q.size() == DEPTH);
      empty_b = (m_q.size() == 0);
      push    = we && !full_b;
      pop     = re && !empty_b;
      m_ovf   = (we && full_b) || (m_ovf && !clr);
      m_udf   = (re && empty_b) || (m_udf && !clr);
      m_valid = m_pend;
      if (m_pend) m_rdata = m_pend_data;
      m_pend = pop;
      if (pop) m_pend_data = m_q.pop_front();
      if (push) m_q.push_back(wd);
    end
  end

`ifndef SYNC_FIFO_TX_FWFT_EN
  always @(negedge clk) begin
    if (!rst) begin
      check("cnt",         32'(o_fifo_cnt),         32'(m_q.size()));
      check("full",        32'(o_fifo_full),        32'(m_q.size() == DEPTH));
      check("almst_full",  32'(o_fifo_almst_full),  32'(m_q.size() >= AF_LIM));
      check("empty",       32'(o_fifo_empty),       32'(m_q.size() == 0));
      check("almst_empty", 32'(o_fifo_almst_empty), 32'(m_q.size() <= AE_LIM));
      check("overflow",    32'(o_overflow),         32'(m_ovf));
      check("underflow",   32'(o_underflow),        32'(m_udf));
      check("rd_valid",    32'(o_rd_valid),         32'(m_valid));
      check("rdata",       32'(o_RDATA),            32'(m_rdata));
    end
  end
`endif

  initial begin
    step();
    step();
    rst = 1'b0;
    step();

`ifdef SYNC_FIFO_TX_FWFT_EN
    check("fwft_reset_empty", 32'(o_fifo_empty), 32'd1);
    we = 1'b1; wd = 8'hA5;
    step();
    we = 1'b0;
    check("fwft_w0_valid", 32'(o_rd_valid), 32'd0);
    check("fwft_w0_cnt",   32'(o_fifo_cnt), 32'd1);
    step();
    check("fwft_w1_valid", 32'(o_rd_valid), 32'd0);
    step();
    check("fwft_w2_valid", 32'(o_rd_valid), 32'd1);
    check("fwft_w2_rdata", 32'(o_RDATA),    32'hA5);
    check("fwft_w2_empty", 32'(o_fifo_empty), 32'd0);
    re = 1'b1;
    step();
    re = 1'b0;
    check("fwft_ack_empty", 32'(o_fifo_empty), 32'd1);
    check("fwft_ack_valid", 32'(o_rd_valid),   32'd0);
    check("fwft_ack_cnt",   32'(o_fifo_cnt),   32'd0);
    check("fwft_ack_udf",   32'(o_underflow),  32'd0);
`else
    // Reset check: underflow set, 7 words stored, then an asynchronous reset.
    re = 1'b1;
    step();
    re = 1'b0;
    check("pre_reset_udf", 32'(o_underflow), 32'd1);
    for (int i = 0; i < 7; i++) begin
      we = 1'b1; wd = 8'(8'h30 + i);
      step();
    end
    we = 1'b0;
    check("pre_reset_cnt", 32'(o_fifo_cnt), 32'd7);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cnt",   32'(o_fifo_cnt),   32'd0);
    check("async_rst_empty", 32'(o_fifo_empty), 32'd1);
    check("async_rst_valid", 32'(o_rd_valid),   32'd0);
    check("async_rst_ovf",   32'(o_overflow),   32'd0);
    check("async_rst_udf",   32'(o_underflow),  32'd0);
    step();
    rst = 1'b0;
    step();

    // Fill 0x00..0x0F, then a rejected 17th push.
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wd = 8'(i);
      step();
      check("fill_almst_full", 32'(o_fifo_almst_full), 32'(i + 1 >= AF_LIM));
      check("fill_full",       32'(o_fifo_full),       32'(i + 1 == DEPTH));
    end
    wd = 8'h10;
    step();
    we = 1'b0;
    check("push17_cnt", 32'(o_fifo_cnt), 32'd16);
    check("push17_ovf", 32'(o_overflow), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("ovf_cleared", 32'(o_overflow), 32'd0);

    // Drain: each word appears one cycle after the edge that popped it.
    for (int i = 0; i < 16; i++) begin
      re = 1'b1;
      step();
      if (i >= 1) check("drain_rdata", 32'(o_RDATA), 32'(i - 1));
      check("drain_almst_empty", 32'(o_fifo_almst_empty), 32'(15 - i <= AE_LIM));
    end
    step();
    re = 1'b0;
    check("drain_last_rdata", 32'(o_RDATA),     32'h0F);
    check("drain_last_valid", 32'(o_rd_valid),  32'd1);
    check("pop17_udf",        32'(o_underflow), 32'd1);
    check("pop17_empty",      32'(o_fifo_empty), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Simultaneous push/pop while empty: only the push lands.
    we = 1'b1; re = 1'b1; wd = 8'h55;
    step();
    re = 1'b0;
    check("sim_empty_cnt", 32'(o_fifo_cnt),  32'd1);
    check("sim_empty_udf", 32'(o_underflow), 32'd1);
    for (int i = 0; i < 7; i++) begin
      wd = 8'(8'h60 + i);
      step();
    end
    clr = 1'b1;
    // Simultaneous push/pop at count 8.
    for (int i = 0; i < 4; i++) begin
      re = 1'b1; wd = 8'(8'h70 + i);
      step();
      clr = 1'b0;
      check("sim_mid_cnt", 32'(o_fifo_cnt), 32'd8);
      if (i == 1) check("sim_mid_rdata", 32'(o_RDATA), 32'h55);
    end
    re = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wd = 8'(8'h80 + i);
      step();
    end
    check("refill_full", 32'(o_fifo_full), 32'd1);

    // Simultaneous push/pop while full: only the pop lands.
    re = 1'b1; wd = 8'hEE;
    step();
    we = 1'b0; re = 1'b0;
    check("sim_full_cnt", 32'(o_fifo_cnt), 32'd15);
    check("sim_full_ovf", 32'(o_overflow), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    re = 1'b1;
    for (int i = 0; i < 15; i++) step();
    re = 1'b0;
    step();
    step();
    check("drained_empty", 32'(o_fifo_empty), 32'd1);

    // Wrap-around stream: 40 words, one push and one pop per cycle.
    for (int i = 0; i <= 41; i++) begin
      we = (i < 40);
      wd = 8'(i);
      re = (i >= 1 && i <= 40);
      step();
      if (i >= 2) begin
        check("stream_rdata", 32'(o_RDATA),    32'(i - 2));
        check("stream_valid", 32'(o_rd_valid), 32'd1);
      end
      if (i <= 39) check("stream_not_empty", 32'(o_fifo_empty), 32'd0);
    end
    we = 1'b0; re = 1'b0;
    step();
    check("stream_end_empty", 32'(o_fifo_empty), 32'd1);
    check("stream_end_ovf",   32'(o_overflow),   32'd0);
    check("stream_end_udf",   32'(o_underflow),  32'd0);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
